periph_bus_ctrl: RTL

Memory-mapped bus controller between the single-cycle MIPS data port and its four data-side slaves: data memory, factorial accelerator, GPIO and PWM. It decodes each CPU access, steers exactly one slave write strobe, inserts per-slave wait states, and returns registered read data with a ready/error handshake. It replaces the ad-hoc write-enable and read-select glue in the top level.

---
 rtl/busctrl_pkg.sv | 39 +++
 rtl/bus_addr_decode.sv | 29 ++
 rtl/periph_bus_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/busctrl_pkg.sv
// Shared definitions for the peripheral bus controller: address map,
// slave-select and FSM state encodings, and a region-match helper.
package busctrl_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Slave select encoding; SEL_NONE marks an unmapped address
  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_DMEM = 3'd1,
    SEL_FACT = 3'd2,
    SEL_GPIO = 3'd3,
    SEL_PWM  = 3'd4
  } slv_sel_e;

  // Address map, decoded on all 32 bits: an address hits a region when
  // (addr & MASK) == BASE.
  localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
  localparam logic [31:0] DMEM_MASK = 32'hFFFF_FF00;
  localparam logic [31:0] FACT_BASE = 32'h0000_0800;
  localparam logic [31:0] FACT_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] GPIO_BASE = 32'h0000_0900;
  localparam logic [31:0] GPIO_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] PWM_BASE  = 32'h0000_0A00;
  localparam logic [31:0] PWM_MASK  = 32'hFFFF_FFF0;

  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: CPU byte address to slave select plus
// a mapped flag.
module bus_addr_decode
  import busctrl_pkg::*;
(
  input  logic [31:0] addr_i,
  output slv_sel_e    sel_o,
  output logic        mapped_o
);

  // Priority-free match: the regions are disjoint, so at most one hits
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    sel_o = SEL_NONE;
    if (in_region(addr_i, DMEM_BASE, DMEM_MASK)) begin
      sel_o = SEL_DMEM;
    end else if (in_region(addr_i, FACT_BASE, FACT_MASK)) begin
      sel_o = SEL_FACT;
    end else if (in_region(addr_i, GPIO_BASE, GPIO_MASK)) begin
      sel_o = SEL_GPIO;
    end else if (in_region(addr_i, PWM_BASE, PWM_MASK)) begin
      sel_o = SEL_PWM;
    end
  end

  assign mapped_o = (sel_o != SEL_NONE);

endmodule

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: memory-mapped bus controller between the CPU data port
// and the DMEM / FACT / GPIO / PWM slaves. Decodes each access, inserts
// per-slave wait states, issues a one-cycle one-hot write strobe and
// returns registered read data with a ready/error handshake.
// Optional feature: define BUSCTRL_TIMEOUT_EN to abort accesses that stay
// in WAIT for TIMEOUT_CYCLES cycles (completes with cpu_err = 1).
module periph_bus_ctrl
  import busctrl_pkg::*;
#(
  parameter int         DMEM_WAIT      = 0,
  parameter int         FACT_WAIT      = 1,
  parameter int         GPIO_WAIT      = 0,
  parameter int         PWM_WAIT       = 0,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  output logic        dmem_we,
  output logic        fact_we,
  output logic        gpio_we,
  output logic        pwm_we,
  input  logic [31:0] dmem_rdata,
  input  logic [31:0] fact_rdata,
  input  logic [31:0] gpio_rdata,
  input  logic [31:0] pwm_rdata,
  input  logic        fact_ready
);

  localparam logic [7:0] DMEM_W = 8'(DMEM_WAIT);
  localparam logic [7:0] FACT_W = 8'(FACT_WAIT);
  localparam logic [7:0] GPIO_W = 8'(GPIO_WAIT);
  localparam logic [7:0] PWM_W  = 8'(PWM_WAIT);

  state_e      state_q, state_d;
  slv_sel_e    sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  slv_sel_e    dec_sel;
  logic        dec_mapped;
  logic [7:0]  wait_load;
  logic [31:0] sel_rdata;
  logic        slave_ready;
  logic        xfer_we;

`ifdef BUSCTRL_TIMEOUT_EN
  logic [7:0]  to_cnt_q, to_cnt_d;
`else
  // The timeout limit has no effect when the timeout path is absent
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  bus_addr_decode u_decode (
    .addr_i   (cpu_addr),
    .sel_o    (dec_sel),
    .mapped_o (dec_mapped)
  );

  // Wait-state count loaded for the slave being addressed in IDLE
  always_comb begin
    wait_load = '0;
    case (dec_sel)
      SEL_DMEM: wait_load = DMEM_W;
      SEL_FACT: wait_load = FACT_W;
      SEL_GPIO: wait_load = GPIO_W;
      SEL_PWM:  wait_load = PWM_W;
      default:  wait_load = '0;
    endcase
  end

  // Read-data mux and readiness of the latched slave
  always_comb begin
    sel_rdata   = '0;
    slave_ready = 1'b1;
    case (sel_q)
      SEL_DMEM: sel_rdata = dmem_rdata;
      SEL_FACT: begin
        sel_rdata   = fact_rdata;
        slave_ready = fact_ready;
      end
      SEL_GPIO: sel_rdata = gpio_rdata;
      SEL_PWM:  sel_rdata = pwm_rdata;
      default:  sel_rdata = '0;
    endcase
  end

  // FSM next-state and datapath next-values
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
`ifdef BUSCTRL_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (dec_mapped) begin
            sel_d      = dec_sel;
            we_d       = cpu_we;
            addr_d     = cpu_addr;
            wdata_d    = cpu_wdata;
            err_d      = 1'b0;
            wait_cnt_d = wait_load;
`ifdef BUSCTRL_TIMEOUT_EN
            to_cnt_d   = '0;
`endif
            state_d    = S_WAIT;
          end else begin
            // Unmapped: complete at once with an error and no strobe
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q != 8'd0) begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end else if (slave_ready) begin
          state_d = S_XFER;
        end
`ifdef BUSCTRL_TIMEOUT_EN
        to_cnt_d = to_cnt_q + 8'd1;
        // A slave that becomes ready on the limit cycle still completes
        if (state_d != S_XFER && to_cnt_d == TIMEOUT_CYCLES) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
`endif
      end
      S_XFER: begin
        rdata_d = we_q ? 32'd0 : sel_rdata;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q    <= S_IDLE;
      sel_q      <= SEL_NONE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
`ifdef BUSCTRL_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef BUSCTRL_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  // Strobes are decoded from registered state, so they last exactly XFER
  assign xfer_we   = (state_q == S_XFER) && we_q;
  assign dmem_we   = xfer_we && (sel_q == SEL_DMEM);
  assign fact_we   = xfer_we && (sel_q == SEL_FACT);
  assign gpio_we   = xfer_we && (sel_q == SEL_GPIO);
  assign pwm_we    = xfer_we && (sel_q == SEL_PWM);

  assign cpu_ready = (state_q == S_RESP);
  assign cpu_err   = err_q && cpu_ready;
  assign cpu_rdata = rdata_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;

endmodule
